// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: instruction field layout,
// the HALT opcode and the prefetch entry record.
package ifetch_pkg;

    localparam int OPCODE_W  = 6;
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RDST2_HI  = 25;
    localparam int RDST2_LO  = 21;
    localparam int RDST1_HI  = 20;
    localparam int RDST1_LO  = 16;
    localparam int RSRC2_HI  = 9;
    localparam int RSRC2_LO  = 5;
    localparam int RSRC1_HI  = 4;
    localparam int RSRC1_LO  = 0;

    localparam logic [OPCODE_W-1:0] OPCODE_HALT = 6'b111111;

    // Widest PC the processor can use; narrower fetch PCs are zero-extended into entries.
    localparam int PC_W = 16;

    typedef struct packed {
        logic [31:0]     code;
        logic [PC_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction word, PC} entries; push, pop and flush in one cycle,
// head shown combinationally and forced to zero while empty.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  ADDR_W = 9,
    parameter int  DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [31:0]       code_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [31:0]       code_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_o  = (count_q != '0);
    assign count_o  = count_q;
    assign do_pop   = pop_i && valid_o;
    // A flush wins over a same-cycle push: the returning word belongs to the old stream.
    assign do_push  = push_i && !flush_i;
    assign wr_entry = '{code: code_i, pc: PC_W'(pc_i)};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head   = mem_q[rd_ptr_q];
    assign code_o = valid_o ? head.code : '0;
    assign pc_o   = valid_o ? ADDR_W'(head.pc) : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency imem reads and feeds
// decode through fetch_fifo. Define FETCH_HALT_EN to stop fetching on the HALT opcode.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       code,
    output logic [ADDR_W-1:0] code_pc,
    output logic              code_valid,
    input  logic              code_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              pop, push, issue, halt_stop;

    assign pop = code_valid && code_ready;
    // Entries held plus the word in flight, after this cycle's pop leaves; issuing only
    // below DEPTH means a returning word always has a free slot.
    assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue     = rst_n && !redirect_valid && !halt_stop &&
                       (occupancy < (CNT_W+1)'(DEPTH));
    assign push      = inflight_q && !redirect_valid && !halt_stop;

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    always_comb begin
        pc_d       = pc_q;
        ret_pc_d   = ret_pc_q;
        inflight_d = issue;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d     = pc_q + ADDR_W'(1);
            ret_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            ret_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_q, halted_d;

    // Once halted, the word already in flight behind the HALT is dropped as well.
    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (push && (opcode_of(imem_rdata) == OPCODE_HALT)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end

    assign halt_stop = halted_q;
`else
    assign halt_stop = 1'b0;
`endif

    assign halted = halt_stop;

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .code_i  (imem_rdata),
        .pc_i    (ret_pc_q),
        .code_o  (code),
        .pc_o    (code_pc),
        .valid_o (code_valid),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table after reset, redirect/wrap/reset
// sequences, then random ready/redirect traffic against an in-order stream model.
module tb_instr_fetch;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = '0;
    logic [31:0]       code;
    logic [ADDR_W-1:0] code_pc;
    logic              code_valid;
    logic              code_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic              halt_en_tb = 1'b0;
    logic [ADDR_W-1:0] halt_addr  = 9'd5;

    // Stream model: the next accepted word must carry exp_pc; occupancy counts
    // requested words not yet accepted since the last flush.
    logic [ADDR_W-1:0] exp_pc = '0;
    int                accepted = 0;
    int                outstanding = 0;
    logic              prev_stall = 1'b0;
    logic [31:0]       prev_code = '0;
    logic [ADDR_W-1:0] prev_pc = '0;

    typedef struct packed {
        logic              rdy;
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              vld;
        logic [ADDR_W-1:0] pc;
        logic [31:0]       code;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .code           (code),
        .code_pc        (code_pc),
        .code_valid     (code_valid),
        .code_ready     (code_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        if (halt_en_tb && (a == halt_addr)) return {6'h3F, 26'(a)};
        return 32'(a) * 32'd3;
    endfunction

    // Synchronous instruction memory; junk on cycles without a request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        logic pop;
        pop = code_valid && code_ready;
        if (prev_stall) begin
            chk("head_hold_valid", code_valid, 1'b1);
            chk("head_hold_code", code, prev_code);
            chk("head_hold_pc", code_pc, prev_pc);
        end
        if (pop) begin
            chk("stream_pc", code_pc, exp_pc);
            chk("stream_code", code, mem_word(exp_pc));
            $display("accept pc=0x%03h code=0x%08h", code_pc, code);
            exp_pc = exp_pc + 1'b1;
            accepted++;
        end
        if (redirect_valid) begin
            chk("no_req_on_redirect", imem_req, 1'b0);
            exp_pc      = redirect_pc;
            outstanding = 0;
        end else begin
            outstanding += int'(imem_req) - int'(pop);
            chk("occupancy_bound", 32'(outstanding <= DEPTH), 1);
        end
        prev_stall = code_valid && !code_ready && !redirect_valid;
        prev_code  = code;
        prev_pc    = code_pc;
    endtask

    // One cycle: drive inputs just after the edge, sample before the falling edge.
    task automatic step(input logic rdy, input logic rv, input logic [ADDR_W-1:0] rpc);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        code_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #3;
        sample();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        code_ready     = 1'b0;
        redirect_valid = 1'b0;
        #3;
        chk("req_low_in_reset", imem_req, 1'b0);
        exp_pc      = '0;
        outstanding = 0;
        prev_stall  = 1'b0;
        accepted    = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] wrap_pc [4];
        logic [31:0]       wrap_code [4];
        int                a0;
        logic              rdy, rv;

        // Cycle 0 is the first cycle with rst_n high; stall with code_ready low in 4..9.
        vecs[0]  = '{1'b1, 1'b1, 9'd0, 1'b0, 9'd0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 9'd1, 1'b0, 9'd0, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 9'd2, 1'b1, 9'd0, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 9'd3, 1'b1, 9'd1, 32'd3};
        for (int i = 4; i < 10; i++) vecs[i] = '{1'b0, 1'b0, 9'd4, 1'b1, 9'd2, 32'd6};
        vecs[10] = '{1'b1, 1'b1, 9'd4, 1'b1, 9'd2, 32'd6};
        vecs[11] = '{1'b1, 1'b1, 9'd5, 1'b1, 9'd3, 32'd9};
        vecs[12] = '{1'b1, 1'b1, 9'd6, 1'b1, 9'd4, 32'd12};
        vecs[13] = '{1'b1, 1'b1, 9'd7, 1'b1, 9'd5, 32'd15};

        wrap_pc[0] = 9'h1FE; wrap_code[0] = 32'h5FA;
        wrap_pc[1] = 9'h1FF; wrap_code[1] = 32'h5FD;
        wrap_pc[2] = 9'h000; wrap_code[2] = 32'h000;
        wrap_pc[3] = 9'h001; wrap_code[3] = 32'h003;

        do_reset();
        chk("reset_halted", halted, 1'b0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rdy, 1'b0, '0);
            chk("tbl_req", imem_req, vecs[i].req);
            if (vecs[i].req) chk("tbl_addr", imem_addr, vecs[i].addr);
            chk("tbl_valid", code_valid, vecs[i].vld);
            chk("tbl_pc", code_pc, vecs[i].pc);
            chk("tbl_code", code, vecs[i].code);
        end

        // Redirect while a word is buffered and another is in flight.
        step(1'b1, 1'b1, 9'h040);
        chk("redir_kept_pc", code_pc, 9'd6);
        step(1'b1, 1'b0, '0);
        chk("redir_t1_valid", code_valid, 1'b0);
        chk("redir_t1_req", imem_req, 1'b1);
        chk("redir_t1_addr", imem_addr, 9'h040);
        step(1'b1, 1'b0, '0);
        chk("redir_t2_valid", code_valid, 1'b0);
        step(1'b1, 1'b0, '0);
        chk("redir_t3_valid", code_valid, 1'b1);
        chk("redir_t3_pc", code_pc, 9'h040);
        chk("redir_t3_code", code, 32'h0C0);

        // Redirect near the top of the address space.
        step(1'b1, 1'b1, 9'h1FE);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, '0);
            chk("wrap_valid", code_valid, 1'b1);
            chk("wrap_pc", code_pc, wrap_pc[k]);
            chk("wrap_code", code, wrap_code[k]);
        end

        // Reset while buffered with a read in flight.
        step(1'b0, 1'b0, '0);
        do_reset();
        step(1'b1, 1'b0, '0);
        chk("rst_valid", code_valid, 1'b0);
        chk("rst_code", code, 32'd0);
        chk("rst_code_pc", code_pc, 9'd0);
        chk("rst_addr", imem_addr, 9'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_first_req", imem_req, 1'b1);
        step(1'b1, 1'b0, '0);
        chk("rst_t1_valid", code_valid, 1'b0);
        step(1'b1, 1'b0, '0);
        chk("rst_t2_valid", code_valid, 1'b1);
        chk("rst_t2_pc", code_pc, 9'd0);
        chk("rst_t2_code", code, 32'd0);

        // Random back-pressure and redirects.
        for (int n = 0; n < 600; n++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 29) == 0);
            step(rdy, rv, ADDR_W'($urandom));
`ifndef FETCH_HALT_EN
            chk("halted_tied_low", halted, 1'b0);
`endif
        end
        a0 = accepted;
        for (int n = 0; n < 10; n++) step(1'b1, 1'b0, '0);
        chk("stream_progress", 32'((accepted - a0) >= 8), 1);

`ifdef FETCH_HALT_EN
        do_reset();
        halt_en_tb = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step(1'b1, 1'b0, '0);
            if (halted) chk("halt_no_req", imem_req, 1'b0);
        end
        chk("halt_words", accepted, 6);
        chk("halt_set", halted, 1'b1);
        chk("halt_drained", code_valid, 1'b0);
        step(1'b1, 1'b1, 9'd0);
        step(1'b1, 1'b0, '0);
        chk("halt_cleared", halted, 1'b0);
        chk("halt_restart_req", imem_req, 1'b1);
        chk("halt_restart_addr", imem_addr, 9'd0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        chk("halt_restart_valid", code_valid, 1'b1);
        chk("halt_restart_pc", code_pc, 9'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
